shift_reg_r: RTL and testbench

SHIFT_REG_R -- requirements
Module: shift_reg_r

---
 rtl/shift_reg_pkg.sv | 25 ++
 rtl/shift_reg_dff_r_en.sv | 26 ++
 rtl/shift_reg_r.sv | 94 +++++++++
 tb/tb_shift_reg_r.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/shift_reg_pkg.sv
// Shared definitions for the shift_reg_r block: operation codes and helpers.
package shift_reg_pkg;

    typedef enum logic [2:0] {
        OP_HOLD = 3'b000,
        OP_LOAD = 3'b001,
        OP_SHL  = 3'b010,
        OP_SHR  = 3'b011,
        OP_ROL  = 3'b100,
        OP_ROR  = 3'b101,
        OP_ASR  = 3'b110,
        OP_CLR  = 3'b111
    } op_e;

    localparam int OP_W = 3;

    // True for every op that advances the shift counter.
    function automatic logic is_shift_op(input logic [OP_W-1:0] op);
        case (op)
            OP_SHL, OP_SHR, OP_ROL, OP_ROR, OP_ASR: is_shift_op = 1'b1;
            default:                                is_shift_op = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/shift_reg_dff_r_en.sv
// Parameterised register with enable, asynchronous active-low reset and
// configurable reset value; the single storage primitive of shift_reg_r.
module dff_r_en #(
    parameter int             W         = 8,
    parameter logic [W-1:0]   RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= RESET_VAL;
        end else if (en) begin
            data_q <= d;
        end
    end

    assign q = data_q;

endmodule

// File: rtl/shift_reg_r.sv
// Multi-function shift register with load/clear, rotate, arithmetic shift
// and a saturating count of shift operations since the last load or clear.
module shift_reg_r
    import shift_reg_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    localparam int              CW        = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] d,
    input  logic             si,
    output logic [WIDTH-1:0] q,
    output logic             so_msb,
    output logic             so_lsb,
    output logic [CW-1:0]    cnt,
    output logic             done
);

    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
    localparam logic [CW-1:0] CNT_DONE = CW'(WIDTH);

    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] q_q;
    logic [CW-1:0]    cnt_d;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_inc;

    // Counter saturates instead of wrapping so done stays asserted.
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);

    always_comb begin
        q_d   = q_q;
        cnt_d = cnt_q;
        case (op)
            OP_HOLD: begin
                q_d   = q_q;
                cnt_d = cnt_q;
            end
            OP_LOAD: begin
                q_d   = d;
                cnt_d = '0;
            end
            OP_SHL:  q_d = {q_q[WIDTH-2:0], si};
            OP_SHR:  q_d = {si, q_q[WIDTH-1:1]};
            OP_ROL:  q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
            OP_ROR:  q_d = {q_q[0], q_q[WIDTH-1:1]};
            OP_ASR:  q_d = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
            OP_CLR: begin
                q_d   = '0;
                cnt_d = '0;
            end
            default: begin
                q_d   = q_q;
                cnt_d = cnt_q;
            end
        endcase
        if (is_shift_op(op)) begin
            cnt_d = cnt_inc;
        end
    end

    dff_r_en #(
        .W         (WIDTH),
        .RESET_VAL (RESET_VAL)
    ) u_q_reg (
        .clk   (clk),
        .rst_n (reset_n),
        .en    (en),
        .d     (q_d),
        .q     (q_q)
    );

    dff_r_en #(
        .W         (CW),
        .RESET_VAL ('0)
    ) u_cnt_reg (
        .clk   (clk),
        .rst_n (reset_n),
        .en    (en),
        .d     (cnt_d),
        .q     (cnt_q)
    );

    assign q      = q_q;
    assign cnt    = cnt_q;
    assign so_msb = q_q[WIDTH-1];
    assign so_lsb = q_q[0];
    assign done   = (cnt_q >= CNT_DONE);

endmodule

// File: tb/tb_shift_reg_r.sv
// Directed self-checking bench for shift_reg_r at WIDTH=8, RESET_VAL=0.
module tb_shift_reg_r;
    import shift_reg_pkg::*;

    localparam int WIDTH = 8;
    localparam int CW    = 4;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             en;
    logic [2:0]       op;
    logic [WIDTH-1:0] d;
    logic             si;
    logic [WIDTH-1:0] q;
    logic             so_msb;
    logic             so_lsb;
    logic [CW-1:0]    cnt;
    logic             done;

    int n_compared   = 0;
    int n_mismatched = 0;

    shift_reg_r #(
        .WIDTH     (WIDTH),
        .RESET_VAL (8'h00)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (en),
        .op      (op),
        .d       (d),
        .si      (si),
        .q       (q),
        .so_msb  (so_msb),
        .so_lsb  (so_lsb),
        .cnt     (cnt),
        .done    (done)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and land 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic e, input logic [2:0] o,
                                  input logic [WIDTH-1:0] dv, input logic s);
        en = e;
        op = o;
        d  = dv;
        si = s;
    endtask

    task automatic check_output(input string tag, input logic [63:0] observed,
                                input logic [63:0] expected);
        n_compared++;
        assert (observed === expected)
        else begin
            n_mismatched++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic check_state(input string tag, input logic [7:0] exp_q,
                               input logic [3:0] exp_cnt, input logic exp_done);
        check_output({tag, " q"},    64'(q),    64'(exp_q));
        check_output({tag, " cnt"},  64'(cnt),  64'(exp_cnt));
        check_output({tag, " done"}, 64'(done), 64'(exp_done));
    endtask

    initial begin
        reset_n = 1'b0;
        apply_stimulus(1'b1, OP_LOAD, 8'hA5, 1'b0);
        repeat (3) step();
        check_state("reset", 8'h00, 4'd0, 1'b0);
        check_output("reset so_msb", 64'(so_msb), 64'd0);

        reset_n = 1'b1;
        step();
        check_state("first load", 8'hA5, 4'd0, 1'b0);

        apply_stimulus(1'b1, OP_LOAD, 8'h81, 1'b0);
        step();
        check_output("so_msb pre-shl", 64'(so_msb), 64'd1);
        check_output("so_lsb pre-shl", 64'(so_lsb), 64'd1);
        apply_stimulus(1'b1, OP_SHL, 8'h00, 1'b0);
        step();
        check_state("shl", 8'h02, 4'd1, 1'b0);
        apply_stimulus(1'b1, OP_SHR, 8'h00, 1'b1);
        step();
        check_state("shr", 8'h81, 4'd2, 1'b0);

        apply_stimulus(1'b1, OP_HOLD, 8'hFF, 1'b1);
        step();
        check_state("hold", 8'h81, 4'd2, 1'b0);

        apply_stimulus(1'b1, OP_ROL, 8'h00, 1'b0);
        step();
        check_state("rol", 8'h03, 4'd3, 1'b0);

        apply_stimulus(1'b1, OP_LOAD, 8'h96, 1'b0);
        step();
        check_state("load 96", 8'h96, 4'd0, 1'b0);
        apply_stimulus(1'b1, OP_ROR, 8'h00, 1'b1);
        step();
        check_state("ror x1", 8'h4B, 4'd1, 1'b0);
        repeat (7) step();
        check_state("ror x8", 8'h96, 4'd8, 1'b1);

        apply_stimulus(1'b1, OP_LOAD, 8'h80, 1'b0);
        step();
        check_state("load 80", 8'h80, 4'd0, 1'b0);
        apply_stimulus(1'b1, OP_ASR, 8'h00, 1'b0);
        step();
        check_state("asr 1", 8'hC0, 4'd1, 1'b0);
        step();
        check_state("asr 2", 8'hE0, 4'd2, 1'b0);

        apply_stimulus(1'b1, OP_LOAD, 8'h01, 1'b0);
        step();
        apply_stimulus(1'b1, OP_SHL, 8'h00, 1'b1);
        repeat (8) step();
        check_state("shl x8", 8'hFF, 4'd8, 1'b1);
        repeat (12) step();
        check_state("shl x20 sat", 8'hFF, 4'd15, 1'b1);
        apply_stimulus(1'b1, OP_CLR, 8'hAA, 1'b1);
        step();
        check_state("clr", 8'h00, 4'd0, 1'b0);

        apply_stimulus(1'b1, OP_LOAD, 8'h3C, 1'b0);
        step();
        apply_stimulus(1'b1, OP_ROL, 8'h00, 1'b0);
        step();
        check_state("rol 3c", 8'h78, 4'd1, 1'b0);
        apply_stimulus(1'b0, OP_CLR, 8'h00, 1'b0);
        step();
        check_state("en0 clr", 8'h78, 4'd1, 1'b0);
        apply_stimulus(1'b0, OP_LOAD, 8'hFF, 1'b0);
        step();
        check_state("en0 load", 8'h78, 4'd1, 1'b0);
        apply_stimulus(1'b1, OP_ROL, 8'h00, 1'b0);
        step();
        check_state("rol 78", 8'hF0, 4'd2, 1'b0);

        #1 reset_n = 1'b0;
        #1;
        check_state("async reset", 8'h00, 4'd0, 1'b0);
        #1 reset_n = 1'b1;
        apply_stimulus(1'b1, OP_LOAD, 8'h5A, 1'b0);
        step();
        check_state("post reset load", 8'h5A, 4'd0, 1'b0);
        apply_stimulus(1'b1, OP_ROL, 8'h00, 1'b0);
        step();
        check_state("post reset rol", 8'hB4, 4'd1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
